// File: rtl/pong_pkg.sv
// Shared definitions for the paddle-game video blocks: FSM states, screen
// defaults, ball size and the one-bit direction flag.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_MISS = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  // DIR_POS moves toward larger row/column, DIR_NEG toward zero
  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  localparam int H_ACTIVE_DEF  = 640;
  localparam int V_ACTIVE_DEF  = 480;
  localparam int BALL_SIZE_DEF = 8;
  localparam int POS_W         = 16;

endpackage

// File: rtl/ball_motion_if.sv
// Frame-level control inputs and ball/game status outputs of ball_motion.
interface ball_motion_if;
  import pong_pkg::*;

  logic                     frame_tick;
  logic                     serve;
  logic                     paddle_hit;
  logic [POS_W-1:0]         ballrow;
  logic [POS_W-1:0]         ballcol;
  logic                     hit_pulse;
  logic                     miss_pulse;
  logic [1:0]               lives;
  logic                     game_over;
  state_e                   state;

  modport master (
    output frame_tick, serve, paddle_hit,
    input  ballrow, ballcol, hit_pulse, miss_pulse, lives, game_over, state
  );

  modport slave (
    input  frame_tick, serve, paddle_hit,
    output ballrow, ballcol, hit_pulse, miss_pulse, lives, game_over, state
  );

endinterface

// File: rtl/ball_axis.sv
// Single-axis step/reflect unit: next position and direction for one frame.
// bounce_i reverses a ball moving toward LIMIT; over_o flags a high-side overrun.
module ball_axis
  import pong_pkg::*;
#(
  parameter int LIMIT = 632
) (
  input  logic [POS_W-1:0] pos_i,
  input  dir_e             dir_i,
  input  logic [POS_W-1:0] speed_i,
  input  logic             bounce_i,
  output logic [POS_W-1:0] pos_o,
  output dir_e             dir_o,
  output logic             bounced_o,
  output logic             over_o
);

  logic [POS_W:0] sum;

  assign sum = {1'b0, pos_i} + {1'b0, speed_i};

  always_comb begin
    pos_o     = pos_i;
    dir_o     = dir_i;
    bounced_o = 1'b0;
    over_o    = 1'b0;
    if (dir_i == DIR_NEG) begin
      if (pos_i < speed_i) begin
        pos_o = '0;
        dir_o = DIR_POS;
      end else begin
        pos_o = pos_i - speed_i;
      end
    end else if (bounce_i) begin
      dir_o     = DIR_NEG;
      bounced_o = 1'b1;
      pos_o     = (pos_i < speed_i) ? '0 : pos_i - speed_i;
    end else if (sum > (POS_W+1)'(LIMIT)) begin
      // clamped to the wall; the row instance treats this as a miss instead
      over_o = 1'b1;
      pos_o  = POS_W'(LIMIT);
      dir_o  = DIR_NEG;
    end else begin
      pos_o = sum[POS_W-1:0];
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Frame-rate ball kinematics and serve/miss/game-over sequencing.
// Optional BALL_SPEEDUP_EN: each paddle bounce raises speed by one up to SPEED_MAX.
module ball_motion
  import pong_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int BALL_SIZE   = BALL_SIZE_DEF,
  parameter int START_ROW   = 236,
  parameter int START_COL   = 316,
  parameter int SPEED_INIT  = 2,
  parameter int SPEED_MAX   = 6,
  parameter int LIVES       = 3,
  parameter int MISS_FRAMES = 60
) (
  input  logic          clk,
  input  logic          rst,
  ball_motion_if.slave  bus
);

  localparam int COL_LIMIT   = H_ACTIVE - BALL_SIZE;
  localparam int ROW_LIMIT   = V_ACTIVE - BALL_SIZE;
  localparam int SPEED_START = (SPEED_INIT > SPEED_MAX) ? SPEED_MAX : SPEED_INIT;

  state_e           state_q, state_d;
  logic [POS_W-1:0] row_q, row_d, col_q, col_d;
  dir_e             dx_q, dx_d, dy_q, dy_d;
  logic [POS_W-1:0] speed_q, speed_d;
  logic [1:0]       lives_q, lives_d;
  logic [POS_W-1:0] miss_cnt_q, miss_cnt_d;
  logic             hit_pulse_q, hit_pulse_d;
  logic             miss_pulse_q, miss_pulse_d;
  logic             game_over_q, game_over_d;

  logic [POS_W-1:0] col_nxt, row_nxt;
  dir_e             dx_nxt, dy_nxt;
  logic             row_bounced, row_over;
  logic             col_bounced_unused, col_over_unused;
  logic             miss_done;

  ball_axis #(.LIMIT(COL_LIMIT)) u_col (
    .pos_i     (col_q),
    .dir_i     (dx_q),
    .speed_i   (speed_q),
    .bounce_i  (1'b0),
    .pos_o     (col_nxt),
    .dir_o     (dx_nxt),
    .bounced_o (col_bounced_unused),
    .over_o    (col_over_unused)
  );

  ball_axis #(.LIMIT(ROW_LIMIT)) u_row (
    .pos_i     (row_q),
    .dir_i     (dy_q),
    .speed_i   (speed_q),
    .bounce_i  (bus.paddle_hit),
    .pos_o     (row_nxt),
    .dir_o     (dy_nxt),
    .bounced_o (row_bounced),
    .over_o    (row_over)
  );

  assign miss_done = (miss_cnt_q == POS_W'(MISS_FRAMES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.serve) state_d = ST_PLAY;
      ST_PLAY: if (bus.frame_tick && row_over) state_d = ST_MISS;
      ST_MISS: if (bus.frame_tick && miss_done)
                 state_d = (lives_q == 2'd0) ? ST_OVER : ST_IDLE;
      ST_OVER: if (bus.serve) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    row_d        = row_q;
    col_d        = col_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    speed_d      = speed_q;
    lives_d      = lives_q;
    miss_cnt_d   = miss_cnt_q;
    hit_pulse_d  = 1'b0;
    miss_pulse_d = 1'b0;
    game_over_d  = (state_d == ST_OVER);
    case (state_q)
      ST_IDLE: begin
        row_d = POS_W'(START_ROW);
        col_d = POS_W'(START_COL);
        if (bus.serve) begin
          dx_d    = DIR_POS;
          dy_d    = DIR_NEG;
          speed_d = POS_W'(SPEED_START);
        end
      end
      ST_PLAY: begin
        if (bus.frame_tick) begin
          col_d = col_nxt;
          dx_d  = dx_nxt;
          if (row_over) begin
            // row is left where it was so the ball freezes at the bottom edge
            miss_pulse_d = 1'b1;
            lives_d      = lives_q - 2'd1;
            miss_cnt_d   = '0;
          end else begin
            row_d       = row_nxt;
            dy_d        = dy_nxt;
            hit_pulse_d = row_bounced;
`ifdef BALL_SPEEDUP_EN
            if (row_bounced)
              speed_d = (speed_q >= POS_W'(SPEED_MAX)) ? POS_W'(SPEED_MAX)
                                                       : speed_q + 1'b1;
`endif
          end
        end
      end
      ST_MISS: begin
        if (bus.frame_tick) begin
          if (miss_done) begin
            miss_cnt_d = '0;
            row_d      = POS_W'(START_ROW);
            col_d      = POS_W'(START_COL);
          end else begin
            miss_cnt_d = miss_cnt_q + 1'b1;
          end
        end
      end
      ST_OVER: begin
        row_d = POS_W'(START_ROW);
        col_d = POS_W'(START_COL);
        if (bus.serve) lives_d = 2'(LIVES);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q        <= POS_W'(START_ROW);
      col_q        <= POS_W'(START_COL);
      dx_q         <= DIR_POS;
      dy_q         <= DIR_NEG;
      speed_q      <= POS_W'(SPEED_START);
      lives_q      <= 2'(LIVES);
      miss_cnt_q   <= '0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      speed_q      <= speed_d;
      lives_q      <= lives_d;
      miss_cnt_q   <= miss_cnt_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
      game_over_q  <= game_over_d;
    end
  end

  assign bus.ballrow    = row_q;
  assign bus.ballcol    = col_q;
  assign bus.hit_pulse  = hit_pulse_q;
  assign bus.miss_pulse = miss_pulse_q;
  assign bus.lives      = lives_q;
  assign bus.game_over  = game_over_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: stimulus pushes expected outputs,
// a monitor pops and compares one cycle after each request.
module tb_ball_motion;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_MISS = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;
`ifdef BALL_SPEEDUP_EN
  localparam int SPD_AFTER_HIT = 3;
`else
  localparam int SPD_AFTER_HIT = 2;
`endif

  typedef struct packed {
    logic [15:0] row;
    logic [15:0] col;
    logic [1:0]  st;
    logic [1:0]  lives;
    logic        hit;
    logic        miss;
    logic        go;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ball_motion_if bus();

  ball_motion dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t  sb[$];
  string nm_q[$];
  int    n_chk = 0;
  int    n_pass = 0;
  logic  req = 1'b0;
  logic  armed = 1'b0;
  logic  arm_async = 1'b0;

  always @(posedge clk) armed <= req;

  always @(negedge clk) begin
    exp_t  e;
    exp_t  a;
    string nm;
    if (armed || arm_async) begin
      a = {bus.ballrow, bus.ballcol, 2'(bus.state), bus.lives,
           bus.hit_pulse, bus.miss_pulse, bus.game_over};
      n_chk++;
      if (sb.size() == 0) begin
        $display("FAIL scoreboard_empty: got row=%0d col=%0d st=%0d, no expectation queued",
                 a.row, a.col, a.st);
      end else begin
        e  = sb.pop_front();
        nm = nm_q.pop_front();
        if (a === e) n_pass++;
        else
          $display("FAIL %s: got row=%0d col=%0d st=%0d lives=%0d hit=%0b miss=%0b go=%0b, want row=%0d col=%0d st=%0d lives=%0d hit=%0b miss=%0b go=%0b",
                   nm, a.row, a.col, a.st, a.lives, a.hit, a.miss, a.go,
                   e.row, e.col, e.st, e.lives, e.hit, e.miss, e.go);
      end
    end
  end

  // Hand-derived trajectory from serve at speed 2: row 236 up to 0 at tick 118,
  // wall hold at 119, then down; col 316 right to 632 at 158, clamp at 159, then left.
  function automatic int exp_row(input int k);
    return (k <= 118) ? 236 - 2*k : 2*(k - 119);
  endfunction

  function automatic int exp_col(input int k);
    return (k <= 158) ? 316 + 2*k : 632 - 2*(k - 159);
  endfunction

  function automatic exp_t mk(input int row, input int col, input logic [1:0] st,
                              input logic [1:0] lv, input logic h, input logic m,
                              input logic g);
    exp_t e;
    e.row = row[15:0]; e.col = col[15:0]; e.st = st; e.lives = lv;
    e.hit = h; e.miss = m; e.go = g;
    return e;
  endfunction

  task automatic step(input logic s, input logic t, input logic h,
                      input exp_t e, input string nm);
    @(negedge clk);
    bus.serve = s; bus.frame_tick = t; bus.paddle_hit = h;
    sb.push_back(e); nm_q.push_back(nm);
    req = 1'b1;
    @(negedge clk);
    bus.serve = 1'b0; bus.frame_tick = 1'b0; bus.paddle_hit = 1'b0;
    req = 1'b0;
  endtask

  // Check between clock edges; optionally assert rst right before looking.
  task automatic async_chk(input bit do_rst, input exp_t e, input string nm);
    @(posedge clk);
    #1;
    if (do_rst) rst = 1'b1;
    sb.push_back(e); nm_q.push_back(nm);
    arm_async = 1'b1;
    @(negedge clk);
    #1 arm_async = 1'b0;
    if (do_rst) begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
    end
  endtask

  task automatic run_ticks(input int k0, input int k1, input logic [1:0] lv);
    for (int k = k0; k <= k1; k++)
      step(1'b0, 1'b1, 1'b0, mk(exp_row(k), exp_col(k), S_PLAY, lv, 1'b0, 1'b0, 1'b0), "play");
  endtask

  // Serve, fly to the bottom without a paddle, miss, and sit out the miss frames.
  task automatic miss_round(input logic [1:0] lv, input logic [1:0] end_st);
    logic [1:0] lv_after;
    lv_after = lv - 2'd1;
    step(1'b1, 1'b0, 1'b0, mk(236, 316, S_PLAY, lv, 1'b0, 1'b0, 1'b0), "serve");
    run_ticks(1, 355, lv);
    step(1'b0, 1'b1, 1'b0, mk(472, exp_col(356), S_MISS, lv_after, 1'b0, 1'b1, 1'b0), "miss");
    step(1'b0, 1'b0, 1'b0, mk(472, exp_col(356), S_MISS, lv_after, 1'b0, 1'b0, 1'b0), "miss_clear");
    step(1'b1, 1'b0, 1'b0, mk(472, exp_col(356), S_MISS, lv_after, 1'b0, 1'b0, 1'b0), "serve_in_miss");
    for (int i = 1; i < 60; i++)
      step(1'b0, 1'b1, 1'b0, mk(472, exp_col(356), S_MISS, lv_after, 1'b0, 1'b0, 1'b0), "miss_hold");
    step(1'b0, 1'b1, 1'b0, mk(236, 316, end_st, lv_after, 1'b0, 1'b0, end_st == S_OVER),
         "miss_exit");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    bus.serve = 1'b0; bus.frame_tick = 1'b0; bus.paddle_hit = 1'b0;
    #2 rst = 1'b1;
    async_chk(1'b0, mk(236, 316, S_IDLE, 2'd3, 1'b0, 1'b0, 1'b0), "reset_state");
    @(negedge clk);
    rst = 1'b0;

    // serve together with a frame tick: serve is taken, no move yet
    step(1'b1, 1'b1, 1'b0, mk(236, 316, S_PLAY, 2'd3, 1'b0, 1'b0, 1'b0), "serve_with_tick");
    run_ticks(1, 354, 2'd3);
    step(1'b0, 1'b1, 1'b1, mk(468, 240, S_PLAY, 2'd3, 1'b1, 1'b0, 1'b0), "paddle_hit");
    step(1'b0, 1'b0, 1'b0, mk(468, 240, S_PLAY, 2'd3, 1'b0, 1'b0, 1'b0), "hit_clear");
    step(1'b0, 1'b1, 1'b1, mk(468 - SPD_AFTER_HIT, 240 - SPD_AFTER_HIT, S_PLAY, 2'd3,
                              1'b0, 1'b0, 1'b0), "hit_while_up");
    async_chk(1'b1, mk(236, 316, S_IDLE, 2'd3, 1'b0, 1'b0, 1'b0), "reset_mid_play");

    // clean restart, serve ignored in PLAY, then first miss
    step(1'b1, 1'b0, 1'b0, mk(236, 316, S_PLAY, 2'd3, 1'b0, 1'b0, 1'b0), "serve_after_rst");
    run_ticks(1, 9, 2'd3);
    step(1'b1, 1'b1, 1'b0, mk(exp_row(10), exp_col(10), S_PLAY, 2'd3, 1'b0, 1'b0, 1'b0),
         "serve_in_play");
    run_ticks(11, 355, 2'd3);
    step(1'b0, 1'b1, 1'b0, mk(472, exp_col(356), S_MISS, 2'd2, 1'b0, 1'b1, 1'b0), "miss1");
    step(1'b0, 1'b0, 1'b0, mk(472, exp_col(356), S_MISS, 2'd2, 1'b0, 1'b0, 1'b0), "miss1_clear");
    for (int i = 1; i < 60; i++)
      step(1'b0, 1'b1, 1'b0, mk(472, exp_col(356), S_MISS, 2'd2, 1'b0, 1'b0, 1'b0), "miss1_hold");
    step(1'b0, 1'b1, 1'b0, mk(236, 316, S_IDLE, 2'd2, 1'b0, 1'b0, 1'b0), "miss1_exit");
    step(1'b0, 1'b1, 1'b0, mk(236, 316, S_IDLE, 2'd2, 1'b0, 1'b0, 1'b0), "tick_in_idle");

    miss_round(2'd2, S_IDLE);
    miss_round(2'd1, S_OVER);

    step(1'b0, 1'b1, 1'b0, mk(236, 316, S_OVER, 2'd0, 1'b0, 1'b0, 1'b1), "tick_in_over");
    step(1'b1, 1'b0, 1'b0, mk(236, 316, S_IDLE, 2'd3, 1'b0, 1'b0, 1'b0), "serve_in_over");
    step(1'b1, 1'b0, 1'b0, mk(236, 316, S_PLAY, 2'd3, 1'b0, 1'b0, 1'b0), "serve_new_game");
    step(1'b0, 1'b1, 1'b0, mk(234, 318, S_PLAY, 2'd3, 1'b0, 1'b0, 1'b0), "new_game_tick");

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain: got %0d expectations left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ball_motion.md
# ball_motion

Frame-rate ball kinematics engine for the paddle game. It owns the ball's row/column registers and advances them once per video frame. It bounces the ball off the left, right and top walls, and reverses it on a paddle hit reported by the collision stage. It also detects misses past the bottom edge and runs the serve / miss / game-over sequence. `ballrow`/`ballcol` feed the collision stage and the pixel renderer, and the collision stage's hit output returns here as `paddle_hit`.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible columns
- `V_ACTIVE`, 480, visible rows
- `BALL_SIZE`, 8, ball edge length in pixels
- `START_ROW`, 236, row loaded at serve and reset
- `START_COL`, 316, column loaded at serve and reset
- `SPEED_INIT`, 2, pixels moved per frame on each axis
- `SPEED_MAX`, 6, speed ceiling (used only with speed-up)
- `LIVES`, 3, misses allowed before game over
- `MISS_FRAMES`, 60, frames the ball is held after a miss

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `frame_tick`  in  1  one-cycle pulse per frame (end of vertical active)
- `serve`  in  1  one-cycle serve request, debounced upstream
- `paddle_hit`  in  1  level from collision stage; ball overlaps paddle
- `ballrow`  out  16  ball top-left row
- `ballcol`  out  16  ball top-left column
- `hit_pulse`  out  1  one cycle on each accepted paddle bounce
- `miss_pulse`  out  1  one cycle on each miss
- `lives`  out  2  remaining lives
- `game_over`  out  1  high in OVER state
- `state`  out  2  current FSM state, for debug/LEDs

## Operation
- FSM states: IDLE=0, PLAY=1, MISS=2, OVER=3.
- IDLE: ball is held at START_ROW/START_COL. A `serve` pulse moves to PLAY with dx=+1 (right), dy=-1 (up) and speed=SPEED_INIT.
- PLAY: all position work happens only on `frame_tick`, in priority order:
  - Column:
    - Moving left with col < speed: col := 0, dx := +1.
    - Moving right with col + speed > H_ACTIVE-BALL_SIZE: col := H_ACTIVE-BALL_SIZE, dx := -1.
    - Otherwise col := col ± speed.
  - Row:
    - Moving up with row < speed: row := 0, dy := +1.
    - Moving down with `paddle_hit`=1: dy := -1, row := row - speed, `hit_pulse`.
    - Moving down with row + speed > V_ACTIVE-BALL_SIZE: miss; `miss_pulse`, lives := lives-1, enter MISS.
    - Otherwise row := row ± speed.
  - A paddle hit beats the miss test on the same tick.
  - A `paddle_hit` while moving up is ignored, so one contact cannot double-bounce.
  - The column and row updates are independent, so a corner reflects both axes on the same tick.
- MISS: the ball freezes at its last position. Count MISS_FRAMES `frame_tick`s, then:
  - lives=0 → OVER
  - otherwise → IDLE, with the position reloaded to start.
- OVER: `game_over`=1 and the ball sits at start. `serve` reloads lives := LIVES and goes to IDLE; it does not start play.
- `serve` is ignored in PLAY and MISS.
- Arithmetic: all 16-bit unsigned. Comparisons are written so that no subtraction underflows (col < speed is tested before col - speed).

## Timing
- Reset values:
  - state=IDLE, ballrow=START_ROW, ballcol=START_COL
  - lives=LIVES, hit_pulse=0, miss_pulse=0, game_over=0
  - dx=+1, dy=-1, speed=SPEED_INIT, miss counter=0
- Latency: every output is registered. A position update is visible on the cycle after `frame_tick` is sampled high.
- `hit_pulse` and `miss_pulse` assert for exactly one cycle, on that same cycle.
- `paddle_hit` is sampled only on the `frame_tick` cycle and is not held internally.
- `serve` is acted on in the cycle it is sampled. `serve` and `frame_tick` together in IDLE: the serve is taken, and the position updates on the next tick.
- `rst` mid-play clears immediately, asynchronously, to the reset values. No pulse is emitted.

## Configuration
- `BALL_SPEEDUP_EN`:
  - Defined: each accepted paddle bounce sets speed := min(speed+1, SPEED_MAX). Speed returns to SPEED_INIT on serve.
  - Undefined: speed is the constant SPEED_INIT, and SPEED_MAX is unused.

## Structure
- Shared package `pong_pkg`:
  - state encoding (IDLE/PLAY/MISS/OVER)
  - H_ACTIVE/V_ACTIVE defaults
  - BALL_SIZE
  - direction encoding (+1/-1 as a 1-bit flag)
- One natural sub-module, `ball_axis`: a single-axis position/direction/reflect unit parameterised by limit. It is instantiated twice (column and row), with the row instance also exporting its bottom-overrun flag for miss detection.

## Test plan
- Reset then serve, 3 frame ticks (speed 2) → ballcol 316→322, ballrow 236→230, state=PLAY.
- Ball at col=631 moving right, tick → ballcol=632, dx flips; next tick → 630.
- Ball moving down at row=470, `paddle_hit`=1 on tick → ballrow=468, hit_pulse for one cycle. With `BALL_SPEEDUP_EN` → next move is 3 px.
- Ball moving down at row=471, `paddle_hit`=0, tick → miss_pulse, lives 3→2, state=MISS. After 60 ticks → IDLE at 236/316.
- Third miss → OVER, game_over=1. serve → lives=3, IDLE, game_over=0.
- `rst` asserted mid-PLAY between ticks → outputs return to reset values in the same cycle, and the next serve starts cleanly.
